// File: rtl/countdown_timer_arbiter.sv
// One countdown timer shared round-robin between NUM_REQ requesters, with a done pulse per job.
// Defining COUNTDOWN_ARB_ABORT_EN adds an abort handshake that cancels the running job.
module countdown_timer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CW         = 16,
  parameter int MAX_AMOUNT = 22,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_REQ-1:0]    req__ENA,
  output logic [NUM_REQ-1:0]    req__RDY,
  input  logic [NUM_REQ*CW-1:0] req_amount,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [IW-1:0]         owner
`ifdef COUNTDOWN_ARB_ABORT_EN
  ,
  input  logic                  abort__ENA,
  output logic                  abort__RDY
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CW-1:0] MaxAmt = CW'(MAX_AMOUNT);

  state_t             state_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CW-1:0]      amt_q [NUM_REQ];
  logic [CW-1:0]      amt_d [NUM_REQ];
  logic [CW-1:0]      counter_q;
  logic [IW-1:0]      rrPtr_q;
  logic [IW-1:0]      owner_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] accept;
  logic [IW-1:0]      winner;
  logic               found;
  logic               abortFire;

  function automatic logic [IW-1:0] wrapInc(input logic [IW-1:0] x);
    if (int'(x) == NUM_REQ - 1) return '0;
    return x + 1'b1;
  endfunction

  // Zero-length requests still take one cycle; long ones are clamped to the limit.
  always_comb begin
    req__RDY = '0;
    accept   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req__RDY[i] = !pending_q[i] && !(state_q != IDLE && int'(owner_q) == i);
      accept[i]   = req__ENA[i] && req__RDY[i];
      if (req_amount[i*CW +: CW] == '0)
        amt_d[i] = CW'(1);
      else if (req_amount[i*CW +: CW] > MaxAmt)
        amt_d[i] = MaxAmt;
      else
        amt_d[i] = req_amount[i*CW +: CW];
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && pending_q[(int'(rrPtr_q) + k) % NUM_REQ]) begin
        winner = IW'((int'(rrPtr_q) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

`ifdef COUNTDOWN_ARB_ABORT_EN
  assign abort__RDY = (state_q == RUN);
  assign abortFire  = abort__ENA && abort__RDY;
`else
  assign abortFire  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      counter_q <= '0;
      rrPtr_q   <= '0;
      owner_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) amt_q[i] <= '0;
    end else begin
      done_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          pending_q[i] <= 1'b1;
          amt_q[i]     <= amt_d[i];
        end
      end
      case (state_q)
        IDLE: begin
          if (found) begin
            owner_q           <= winner;
            pending_q[winner] <= 1'b0;
            counter_q         <= amt_q[winner] - 1'b1;
            state_q           <= RUN;
            busy_q            <= 1'b1;
          end
        end
        // An abort on the final count still wins, so no done is raised.
        RUN: begin
          if (abortFire) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rrPtr_q <= wrapInc(owner_q);
          end else if (counter_q == '0) begin
            state_q         <= DONE;
            done_q[owner_q] <= 1'b1;
          end else begin
            counter_q <= counter_q - 1'b1;
          end
        end
        DONE: begin
          rrPtr_q <= wrapInc(owner_q);
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Self-checking bench for countdown_timer_arbiter: job-schedule model compared every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_countdown_timer_arbiter;

  localparam int NR   = 4;
  localparam int CW   = 16;
  localparam int MAXA = 22;

  logic             CLK;
  logic             nRST;
  logic [NR-1:0]    req__ENA;
  logic [NR-1:0]    req__RDY;
  logic [NR*CW-1:0] req_amount;
  logic [NR-1:0]    done;
  logic             busy;
  logic [1:0]       owner;
  logic             abortEna;
  logic             abortRdy;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;
  int doneSeen;

  countdown_timer_arbiter #(.NUM_REQ(NR), .CW(CW), .MAX_AMOUNT(MAXA)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req__ENA   (req__ENA),
    .req__RDY   (req__RDY),
    .req_amount (req_amount),
    .done       (done),
    .busy       (busy),
    .owner      (owner)
`ifdef COUNTDOWN_ARB_ABORT_EN
    ,
    .abort__ENA (abortEna),
    .abort__RDY (abortRdy)
`endif
  );

`ifndef COUNTDOWN_ARB_ABORT_EN
  assign abortRdy = 1'b0;
`endif

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: a job is described by its owner and the absolute cycles where it starts and finishes.
  bit            mActive;
  int            mStart, mEnd, mCyc;
  int            mOwner, mPtr;
  bit [NR-1:0]   mPend;
  int            mAmt [NR];
  logic [NR-1:0] mAcc;
  bit            mAbortNow, mGranted;
  int            mIdx;

  function automatic int clampAmt(input logic [CW-1:0] a);
    if (a == '0) return 1;
    if (a > CW'(MAXA)) return MAXA;
    return int'(a);
  endfunction

  function automatic logic [NR-1:0] modelRdy();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = !mPend[i] && !(mActive && mOwner == i);
    return r;
  endfunction

  function automatic logic [NR-1:0] modelDone();
    logic [NR-1:0] one;
    one = 1;
    if (mActive && mCyc == mEnd) return one << mOwner;
    return '0;
  endfunction

  function automatic bit modelAbortRdy();
    return mActive && (mCyc < mEnd);
  endfunction

  initial mCyc = 0;

  always @(posedge CLK) begin
    if (!nRST) begin
      mActive = 1'b0;
      mPend   = '0;
      mPtr    = 0;
      mOwner  = 0;
      for (int i = 0; i < NR; i++) mAmt[i] = 0;
    end else begin
      mAcc = req__ENA & modelRdy();
`ifdef COUNTDOWN_ARB_ABORT_EN
      mAbortNow = abortEna && modelAbortRdy();
`else
      mAbortNow = 1'b0;
`endif
      if (!mActive) begin
        mGranted = 1'b0;
        for (int k = 0; k < NR; k++) begin
          mIdx = (mPtr + k) % NR;
          if (!mGranted && mPend[mIdx]) begin
            mGranted    = 1'b1;
            mActive     = 1'b1;
            mOwner      = mIdx;
            mStart      = mCyc + 1;
            mEnd        = mCyc + 1 + mAmt[mIdx];
            mPend[mIdx] = 1'b0;
          end
        end
      end else if (mAbortNow || mCyc == mEnd) begin
        mActive = 1'b0;
        mPtr    = (mOwner + 1) % NR;
      end
      for (int i = 0; i < NR; i++) begin
        if (mAcc[i]) begin
          mPend[i] = 1'b1;
          mAmt[i]  = clampAmt(req_amount[i*CW +: CW]);
        end
      end
    end
    mCyc = mCyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("busy",  32'(busy),     32'(mActive));
      checkOutput("owner", 32'(owner),    32'(mOwner));
      checkOutput("done",  32'(done),     32'(modelDone()));
      checkOutput("rdy",   32'(req__RDY), 32'(modelRdy()));
`ifdef COUNTDOWN_ARB_ABORT_EN
      checkOutput("abortRdy", 32'(abortRdy), 32'(modelAbortRdy()));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      req__ENA = '0;
      abortEna = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] ena, input int a0, input int a1,
                               input int a2, input int a3);
    req__ENA   = ena;
    req_amount = {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endtask

  task automatic doReset();
    nRST = 1'b0;
    tick(2);
    nRST = 1'b1;
  endtask

  initial begin
    nRST       = 1'b0;
    req__ENA   = '0;
    req_amount = '0;
    abortEna   = 1'b0;
    tick(2);
    checkEn = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_busy",  32'(busy),     32'h0);
    checkOutput("rst_done",  32'(done),     32'h0);
    checkOutput("rst_owner", 32'(owner),    32'h0);
    checkOutput("rst_rdy",   32'(req__RDY), 32'hF);
    nRST = 1'b1;

    $display("[TB] single job amount 5");
    tick(1);
    applyStimulus(4'b0001, 5, 0, 0, 0);
    tick(1);
    checkOutput("t1_rdy_c1",  32'(req__RDY), 32'hE);
    checkOutput("t1_busy_c1", 32'(busy),     32'h0);
    tick(1);
    checkOutput("t1_busy_c2", 32'(busy),     32'h1);
    tick(4);
    checkOutput("t1_done_c6", 32'(done),     32'h0);
    tick(1);
    checkOutput("t1_done_c7", 32'(done),     32'h1);
    tick(1);
    checkOutput("t1_busy_c8", 32'(busy),     32'h0);
    checkOutput("t1_rdy_c8",  32'(req__RDY), 32'hF);

    $display("[TB] four simultaneous jobs amount 3");
    doReset();
    applyStimulus(4'b1111, 3, 3, 3, 3);
    tick(5);
    checkOutput("t2_done0", 32'(done),  32'h1);
    tick(2);
    checkOutput("t2_owner1", 32'(owner), 32'h1);
    tick(3);
    checkOutput("t2_done1", 32'(done),  32'h2);
    tick(5);
    checkOutput("t2_done2", 32'(done),  32'h4);
    tick(5);
    checkOutput("t2_done3", 32'(done),  32'h8);
    tick(2);

    $display("[TB] round-robin fairness");
    doReset();
    applyStimulus(4'b0010, 0, 4, 0, 0);
    tick(3);
    applyStimulus(4'b0101, 2, 0, 2, 0);
    tick(5);
    checkOutput("t3_owner2", 32'(owner), 32'h2);
    tick(2);
    checkOutput("t3_done2", 32'(done),  32'h4);
    tick(4);
    checkOutput("t3_done0", 32'(done),  32'h1);
    tick(2);

    $display("[TB] amount boundaries 0 and 100");
    doReset();
    applyStimulus(4'b0001, 0, 0, 0, 0);
    tick(2);
    checkOutput("t4_busy_zero", 32'(busy), 32'h1);
    tick(1);
    checkOutput("t4_done_zero", 32'(done), 32'h1);
    tick(1);
    applyStimulus(4'b0001, 100, 0, 0, 0);
    tick(23);
    checkOutput("t4_done_early", 32'(done), 32'h0);
    tick(1);
    checkOutput("t4_done_clamp", 32'(done), 32'h1);
    tick(2);

    $display("[TB] reset during run");
    doReset();
    applyStimulus(4'b0001, 10, 0, 0, 0);
    tick(2);
    applyStimulus(4'b0110, 0, 3, 3, 0);
    tick(2);
    nRST = 1'b0;
    tick(1);
    checkOutput("t5_busy", 32'(busy),     32'h0);
    checkOutput("t5_rdy",  32'(req__RDY), 32'hF);
    nRST     = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      tick(1);
      if (done != '0) doneSeen = doneSeen + 1;
    end
    checkOutput("t5_no_done", 32'(doneSeen), 32'h0);

`ifdef COUNTDOWN_ARB_ABORT_EN
    $display("[TB] abort in second run cycle");
    doReset();
    applyStimulus(4'b0011, 10, 3, 0, 0);
    tick(3);
    checkOutput("t6_abort_rdy", 32'(abortRdy), 32'h1);
    abortEna = 1'b1;
    tick(1);
    checkOutput("t6_busy_idle", 32'(busy), 32'h0);
    checkOutput("t6_done_none", 32'(done), 32'h0);
    tick(1);
    checkOutput("t6_owner1", 32'(owner), 32'h1);
    tick(3);
    checkOutput("t6_done1", 32'(done), 32'h2);
    tick(4);
    checkOutput("t6_no_done0", 32'(done), 32'h0);
    tick(2);
`endif

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
